ctrl_pipe: RTL

//  Pipelined MIPS decode/control for the ID stage. Decodes the ID instruction into the

---
 rtl/ctrl_pipe.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: MIPS ID-stage decode/control with ID/EX register, load-use stall and HI/LO sequencing
module ctrl_pipe #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        flush_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rt_i,
    output logic        stall_o,
    output logic        illegal_o,
    output logic        valid_o,
    output logic [1:0]  RegDst_o,
    output logic [1:0]  ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  EXTOp_o,
    output logic [1:0]  MemtoReg_o,
    output logic [1:0]  Jump_o,
    output logic [4:0]  ALUOp_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        RegWrite_o,
    output logic        md_start_o,
    output logic [1:0]  md_op_o,
    output logic        md_busy_o,
    output logic        md_done_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR   = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [4:0] ALUOP_ADD = 5'd0,  ALUOP_ADDU = 5'd1,  ALUOP_SUB = 5'd2,  ALUOP_SUBU = 5'd3;
    localparam logic [4:0] ALUOP_AND = 5'd4,  ALUOP_OR   = 5'd5,  ALUOP_XOR = 5'd6,  ALUOP_NOR  = 5'd7;
    localparam logic [4:0] ALUOP_SLT = 5'd8,  ALUOP_SLTU = 5'd9,  ALUOP_SLL = 5'd10, ALUOP_SRL  = 5'd11;
    localparam logic [4:0] ALUOP_SRA = 5'd12, ALUOP_LUI  = 5'd13, ALUOP_EQ  = 5'd14, ALUOP_NE   = 5'd15;
    localparam logic [4:0] ALUOP_PC8 = 5'd16;

    localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
    localparam logic [1:0] SRCA_RS = 2'b00, SRCA_SHAMT = 2'b01, SRCA_PC = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_IMM = 2'b01;
    localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b00, WB_MEM = 2'b01, WB_HI = 2'b10, WB_LO = 2'b11;
    localparam logic [1:0] JMP_NONE = 2'b00, JMP_BR = 2'b01, JMP_IMM = 2'b10, JMP_REG = 2'b11;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ext_op;
        logic [1:0] mem_to_reg;
        logic [1:0] jump;
        logic [4:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt;
    logic [4:0] r_alu, i_alu;
    ctrl_t      dec, ctrl_d, ctrl_q;
    logic       legal, rt_src, is_md, is_mf;
    logic       load_use, md_hazard, accept, issue, md_go;
    logic       valid_q, illegal_q, illegal_d;
    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_load;
    logic       start_q, start_d, done_q, done_d;
    logic [1:0] op_q, op_d;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[15:6];

    assign i_alu = (opcode == OP_ADDI)  ? ALUOP_ADD  :
                   (opcode == OP_ADDIU) ? ALUOP_ADDU :
                   (opcode == OP_SLTI)  ? ALUOP_SLT  :
                   (opcode == OP_SLTIU) ? ALUOP_SLTU :
                   (opcode == OP_ANDI)  ? ALUOP_AND  :
                   (opcode == OP_ORI)   ? ALUOP_OR   :
                   (opcode == OP_XORI)  ? ALUOP_XOR  : ALUOP_LUI;

    // ALU operation for the register-register and shift function codes
    always_comb begin
        case (funct)
            F_ADD:                r_alu = ALUOP_ADD;
            F_ADDU:               r_alu = ALUOP_ADDU;
            F_SUB:                r_alu = ALUOP_SUB;
            F_SUBU:               r_alu = ALUOP_SUBU;
            F_AND:                r_alu = ALUOP_AND;
            F_OR:                 r_alu = ALUOP_OR;
            F_XOR:                r_alu = ALUOP_XOR;
            F_NOR:                r_alu = ALUOP_NOR;
            F_SLT:                r_alu = ALUOP_SLT;
            F_SLTU:               r_alu = ALUOP_SLTU;
            F_SLL, F_SLLV:        r_alu = ALUOP_SLL;
            F_SRL, F_SRLV:        r_alu = ALUOP_SRL;
            F_SRA, F_SRAV:        r_alu = ALUOP_SRA;
            default:              r_alu = ALUOP_ADD;
        endcase
    end

    // Instruction decode into the control bundle; unknown encodings stay an all-zero bubble
    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        rt_src = 1'b0;
        is_md  = 1'b0;
        is_mf  = 1'b0;
        if (instr == 32'd0) begin
            legal = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                        F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV: begin
                            legal         = 1'b1;
                            rt_src        = 1'b1;
                            dec.reg_dst   = DST_RD;
                            dec.alu_op    = r_alu;
                            dec.reg_write = 1'b1;
                        end
                        F_SLL, F_SRL, F_SRA: begin
                            legal         = 1'b1;
                            rt_src        = 1'b1;
                            dec.reg_dst   = DST_RD;
                            dec.alu_src_a = SRCA_SHAMT;
                            dec.alu_op    = r_alu;
                            dec.reg_write = 1'b1;
                        end
                        F_JR: begin
                            legal    = 1'b1;
                            dec.jump = JMP_REG;
                        end
                        F_JALR: begin
                            legal         = 1'b1;
                            dec.reg_dst   = DST_RD;
                            dec.alu_src_a = SRCA_PC;
                            dec.alu_op    = ALUOP_PC8;
                            dec.jump      = JMP_REG;
                            dec.reg_write = 1'b1;
                        end
                        F_MFHI, F_MFLO: begin
                            legal          = 1'b1;
                            is_mf          = 1'b1;
                            dec.reg_dst    = DST_RD;
                            dec.mem_to_reg = (funct == F_MFHI) ? WB_HI : WB_LO;
                            dec.reg_write  = 1'b1;
                        end
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            legal  = 1'b1;
                            rt_src = 1'b1;
                            is_md  = 1'b1;
                        end
                        default: legal = 1'b0;
                    endcase
                end
                OP_J: begin
                    legal    = 1'b1;
                    dec.jump = JMP_IMM;
                end
                OP_JAL: begin
                    legal         = 1'b1;
                    dec.reg_dst   = DST_RA;
                    dec.alu_src_a = SRCA_PC;
                    dec.alu_op    = ALUOP_PC8;
                    dec.jump      = JMP_IMM;
                    dec.reg_write = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    legal      = 1'b1;
                    rt_src     = 1'b1;
                    dec.ext_op = EXT_SIGN;
                    dec.jump   = JMP_BR;
                    dec.alu_op = (opcode == OP_BEQ) ? ALUOP_EQ : ALUOP_NE;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                    legal         = 1'b1;
                    dec.alu_src_b = SRCB_IMM;
                    dec.ext_op    = EXT_SIGN;
                    dec.alu_op    = i_alu;
                    dec.reg_write = 1'b1;
                end
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    legal         = 1'b1;
                    dec.alu_src_b = SRCB_IMM;
                    dec.ext_op    = EXT_ZERO;
                    dec.alu_op    = i_alu;
                    dec.reg_write = 1'b1;
                end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    legal          = 1'b1;
                    dec.alu_src_b  = SRCB_IMM;
                    dec.ext_op     = EXT_SIGN;
                    dec.alu_op     = ALUOP_ADDU;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = WB_MEM;
                    dec.reg_write  = 1'b1;
                end
                OP_SB, OP_SH, OP_SW: begin
                    legal         = 1'b1;
                    rt_src        = 1'b1;
                    dec.alu_src_b = SRCB_IMM;
                    dec.ext_op    = EXT_SIGN;
                    dec.alu_op    = ALUOP_ADDU;
                    dec.mem_write = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Hazards: the md hazard releases on the last busy cycle so the waiting instruction lands on the done edge
    assign load_use  = ex_memread_i & (ex_rt_i != 5'd0) & ((ex_rt_i == rs) | ((ex_rt_i == rt) & rt_src));
    assign md_hazard = md_busy_o & (is_md | is_mf) & (cnt_q != '0);
    assign stall_o   = instr_valid & ~flush_i & (load_use | md_hazard);
    assign accept    = instr_valid & ~flush_i & ~stall_o;
    assign issue     = accept & legal;
    assign md_go     = issue & is_md;
    assign ctrl_d    = issue ? dec : '0;
    assign illegal_d = instr_valid & ~flush_i & ~legal;
    assign cnt_load  = funct[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= issue;
            illegal_q <= illegal_d;
        end
    end

    // HI/LO sequencer next state; a new op may launch on the same edge the previous one completes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        op_d    = 2'b00;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (md_go) begin
                state_d = BUSY;
                cnt_d   = cnt_load;
                start_d = 1'b1;
                op_d    = funct[1:0];
            end
        end else if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = md_go ? BUSY : IDLE;
            cnt_d   = md_go ? cnt_load : '0;
            start_d = md_go;
            op_d    = md_go ? funct[1:0] : 2'b00;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // HI/LO sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            op_q    <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign valid_o    = valid_q;
    assign illegal_o  = illegal_q;
    assign RegDst_o   = ctrl_q.reg_dst;
    assign ALUSrcA_o  = ctrl_q.alu_src_a;
    assign ALUSrcB_o  = ctrl_q.alu_src_b;
    assign EXTOp_o    = ctrl_q.ext_op;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    assign Jump_o     = ctrl_q.jump;
    assign ALUOp_o    = ctrl_q.alu_op;
    assign MemRead_o  = ctrl_q.mem_read;
    assign MemWrite_o = ctrl_q.mem_write;
    assign RegWrite_o = ctrl_q.reg_write;
    assign md_start_o = start_q;
    assign md_op_o    = op_q;
    assign md_busy_o  = (state_q == BUSY);
    assign md_done_o  = done_q;

endmodule
